// File: rtl/argscan_2d_pkg.sv
// Shared types for the argscan_2d block: FSM state and job mode encodings.
package argscan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_MIN = 1'b1
    } mode_t;

endpackage

// File: rtl/argscan_2d_if.sv
// Job/result handshake bundle for argscan_2d.
// Optional result_sum signal is present only when ARGSCAN_SUM_EN is defined.
interface argscan_2d_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int SUM_W = DATA_WIDTH + $clog2(ROWS * COLS);

    logic                  in_valid;
    logic                  in_ready;
    logic                  mode_in;
    logic [DATA_WIDTH-1:0] array_in [ROWS][COLS];
    logic                  abort;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [ROW_W-1:0]      result_row;
    logic [COL_W-1:0]      result_col;
    logic                  busy;
`ifdef ARGSCAN_SUM_EN
    logic [SUM_W-1:0]      result_sum;

    modport slave (
        input  in_valid, mode_in, array_in, abort, out_ready,
        output in_ready, out_valid, result, result_row, result_col, busy, result_sum
    );
    modport master (
        output in_valid, mode_in, array_in, abort, out_ready,
        input  in_ready, out_valid, result, result_row, result_col, busy, result_sum
    );
`else
    modport slave (
        input  in_valid, mode_in, array_in, abort, out_ready,
        output in_ready, out_valid, result, result_row, result_col, busy
    );
    modport master (
        output in_valid, mode_in, array_in, abort, out_ready,
        input  in_ready, out_valid, result, result_row, result_col, busy
    );
`endif

endinterface

// File: rtl/argscan_2d_lane_reduce.sv
// Combinational reduction of LANES candidates against the running best.
// Strict compare applied lane 0 first, so ties keep the lowest index.
module argscan_lane_reduce
    import argscan_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2,
    parameter int ROW_W      = 3,
    parameter int COL_W      = 3,
    parameter int SIGNED     = 0
) (
    input  mode_t                 mode_i,
    input  logic [DATA_WIDTH-1:0] best_val_i,
    input  logic [ROW_W-1:0]      best_row_i,
    input  logic [COL_W-1:0]      best_col_i,
    input  logic [DATA_WIDTH-1:0] cand_val_i [LANES],
    input  logic [ROW_W-1:0]      cand_row_i [LANES],
    input  logic [COL_W-1:0]      cand_col_i [LANES],
    output logic [DATA_WIDTH-1:0] best_val_o,
    output logic [ROW_W-1:0]      best_row_o,
    output logic [COL_W-1:0]      best_col_o
);

    function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) greater = ($signed(a) > $signed(b));
        else             greater = (a > b);
    endfunction

    // Walk the lanes in order, replacing the best only on a strict improvement.
    always_comb begin
        logic [DATA_WIDTH-1:0] val_v;
        logic [ROW_W-1:0]      row_v;
        logic [COL_W-1:0]      col_v;
        logic                  take_v;
        val_v  = best_val_i;
        row_v  = best_row_i;
        col_v  = best_col_i;
        take_v = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (mode_i == MODE_MAX) take_v = greater(cand_val_i[l], val_v);
            else                    take_v = greater(val_v, cand_val_i[l]);
            if (take_v) begin
                val_v = cand_val_i[l];
                row_v = cand_row_i[l];
                col_v = cand_col_i[l];
            end else begin
                val_v = val_v;
            end
        end
        best_val_o = val_v;
        best_row_o = row_v;
        best_col_o = col_v;
    end

endmodule

// File: rtl/argscan_2d.sv
// argscan_2d: captures a ROWS x COLS array and scans it LANES elements per
// cycle in row-major order, reporting the max or min value and its position.
// Optional feature macro: ARGSCAN_SUM_EN adds result_sum (sum of all elements).
module argscan_2d
    import argscan_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int LANES      = 2,
    parameter int SIGNED     = 0
) (
    input  logic        clk,
    input  logic        rst,
    argscan_2d_if.slave bus
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int SUM_W = DATA_WIDTH + IDX_W;
    localparam logic [IDX_W-1:0] LAST_P = IDX_W'(N - LANES);

    if (ROWS < 2 || COLS < 2) begin : g_dim_chk
        $error("argscan_2d: ROWS and COLS must both be >= 2");
    end
    if (LANES < 1 || (N % LANES) != 0) begin : g_lane_chk
        $error("argscan_2d: LANES must divide ROWS*COLS");
    end

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] flat_q [N];
    mode_t                 mode_q;
    logic [IDX_W-1:0]      p_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic [DATA_WIDTH-1:0] best_val_q;
    logic [ROW_W-1:0]      best_row_q;
    logic [COL_W-1:0]      best_col_q;
    logic                  accept_s, step_s, done_s;
    logic [DATA_WIDTH-1:0] lane_val_s [LANES];
    logic [ROW_W-1:0]      lane_row_s [LANES];
    logic [COL_W-1:0]      lane_col_s [LANES];
    logic [ROW_W-1:0]      next_row_s;
    logic [COL_W-1:0]      next_col_s;
    logic [DATA_WIDTH-1:0] red_val_s;
    logic [ROW_W-1:0]      red_row_s;
    logic [COL_W-1:0]      red_col_s;
    logic                  in_ready_q, out_valid_q, busy_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [ROW_W-1:0]      result_row_q;
    logic [COL_W-1:0]      result_col_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and control strobes; abort beats completion, accept beats abort.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        step_s   = 1'b0;
        done_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    state_d  = SCAN;
                end else begin
                    state_d  = IDLE;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (p_q == LAST_P) begin
                        done_s  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            HOLD: begin
                if (bus.abort || bus.out_ready) state_d = IDLE;
                else                            state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-lane candidates and row/col positions from wrapping counters.
    always_comb begin
        logic [ROW_W-1:0] r_v;
        logic [COL_W-1:0] c_v;
        r_v = row_q;
        c_v = col_q;
        for (int l = 0; l < LANES; l++) begin
            lane_val_s[l] = flat_q[p_q + IDX_W'(l)];
            lane_row_s[l] = r_v;
            lane_col_s[l] = c_v;
            if (c_v == COL_W'(COLS - 1)) begin
                c_v = '0;
                r_v = r_v + ROW_W'(1);
            end else begin
                c_v = c_v + COL_W'(1);
            end
        end
        next_row_s = r_v;
        next_col_s = c_v;
    end

    argscan_lane_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W),
        .SIGNED     (SIGNED)
    ) u_reduce (
        .mode_i     (mode_q),
        .best_val_i (best_val_q),
        .best_row_i (best_row_q),
        .best_col_i (best_col_q),
        .cand_val_i (lane_val_s),
        .cand_row_i (lane_row_s),
        .cand_col_i (lane_col_s),
        .best_val_o (red_val_s),
        .best_row_o (red_row_s),
        .best_col_o (red_col_s)
    );

    // Job capture and scan datapath; best seeds from element [0][0], not zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) flat_q[i] <= '0;
            mode_q     <= MODE_MAX;
            p_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            best_val_q <= '0;
            best_row_q <= '0;
            best_col_q <= '0;
        end else if (accept_s) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    flat_q[r*COLS + c] <= bus.array_in[r][c];
            mode_q     <= mode_t'(bus.mode_in);
            p_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            best_val_q <= bus.array_in[0][0];
            best_row_q <= '0;
            best_col_q <= '0;
        end else if (step_s) begin
            p_q        <= p_q + IDX_W'(LANES);
            row_q      <= next_row_s;
            col_q      <= next_col_s;
            best_val_q <= red_val_s;
            best_row_q <= red_row_s;
            best_col_q <= red_col_s;
        end
    end

    // Registered handshake flags and result, updated only on entering HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
            result_row_q <= '0;
            result_col_q <= '0;
        end else begin
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
            if (done_s) begin
                result_q     <= red_val_s;
                result_row_q <= red_row_s;
                result_col_q <= red_col_s;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.result     = result_q;
    assign bus.result_row = result_row_q;
    assign bus.result_col = result_col_q;

`ifdef ARGSCAN_SUM_EN
    logic [SUM_W-1:0] sum_q, sum_step_s, result_sum_q;

    function automatic logic [SUM_W-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        if (SIGNED != 0) ext = {{(SUM_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
        else             ext = {{(SUM_W-DATA_WIDTH){1'b0}}, v};
    endfunction

    // Running sum including this cycle's lanes.
    always_comb begin
        sum_step_s = sum_q;
        for (int l = 0; l < LANES; l++) sum_step_s = sum_step_s + ext(lane_val_s[l]);
    end

    // Accumulator clears on accept; published sum moves with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q        <= '0;
            result_sum_q <= '0;
        end else begin
            if (accept_s)    sum_q <= '0;
            else if (step_s) sum_q <= sum_step_s;
            if (done_s) result_sum_q <= sum_step_s;
        end
    end

    assign bus.result_sum = result_sum_q;
`endif

endmodule

// File: tb/tb_argscan_2d.sv
// Directed bench for argscan_2d: an unsigned and a signed instance share the
// same stimulus and are compared each cycle against a reference model.
module tb_argscan_2d;
    import argscan_pkg::*;

    localparam int DW = 8;
    localparam int R  = 8;
    localparam int C  = 8;
    localparam int L  = 2;
    localparam int N  = R * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid  = 1'b0;
    logic          mode      = 1'b0;
    logic          abort     = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] arr [R][C];

    int n_checks = 0;
    int n_pass   = 0;

    argscan_2d_if #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) bus_u ();
    argscan_2d_if #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) bus_s ();

    for (genvar r = 0; r < R; r++) begin : g_r
        for (genvar c = 0; c < C; c++) begin : g_c
            assign bus_u.array_in[r][c] = arr[r][c];
            assign bus_s.array_in[r][c] = arr[r][c];
        end
    end
    assign bus_u.in_valid  = in_valid;
    assign bus_s.in_valid  = in_valid;
    assign bus_u.mode_in   = mode;
    assign bus_s.mode_in   = mode;
    assign bus_u.abort     = abort;
    assign bus_s.abort     = abort;
    assign bus_u.out_ready = out_ready;
    assign bus_s.out_ready = out_ready;

    argscan_2d #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .LANES(L), .SIGNED(0))
        u_dut (.clk(clk), .rst(rst), .bus(bus_u));
    argscan_2d #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .LANES(L), .SIGNED(1))
        u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    // Reference: find the extreme value, then its first row-major position.
    function automatic void ref_scan(input logic [DW-1:0] a [R][C], input bit find_min,
                                     input bit sgn, output int val, output int row,
                                     output int col, output int sum);
        int best;
        int v;
        bit found;
        sum  = 0;
        best = find_min ? 100000 : -100000;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                v = sgn ? int'($signed(a[r][c])) : int'(a[r][c]);
                sum += v;
                if (find_min ? (v < best) : (v > best)) best = v;
            end
        found = 1'b0;
        row = 0;
        col = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                v = sgn ? int'($signed(a[r][c])) : int'(a[r][c]);
                if (!found && v == best) begin
                    found = 1'b1;
                    row = r;
                    col = c;
                end
            end
        val = best;
    endfunction

    int cur_val [2], cur_row [2], cur_col [2], cur_sum [2];
    int pend_val[2], pend_row[2], pend_col[2], pend_sum[2];
    int exp_val [2], exp_row [2], exp_col [2], exp_sum [2];
    int ph  = 0;   // 0 idle, 1 scanning, 2 result held
    int cnt = 0;

    always_comb begin
        ref_scan(arr, mode, 1'b0, cur_val[0], cur_row[0], cur_col[0], cur_sum[0]);
        ref_scan(arr, mode, 1'b1, cur_val[1], cur_row[1], cur_col[1], cur_sum[1]);
    end

    // Job timeline: N/L scan cycles after accept, held until consumed or aborted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph  <= 0;
            cnt <= 0;
            for (int k = 0; k < 2; k++) begin
                exp_val[k] <= 0; exp_row[k] <= 0; exp_col[k] <= 0; exp_sum[k] <= 0;
            end
        end else begin
            case (ph)
                0: if (in_valid) begin
                    ph  <= 1;
                    cnt <= 0;
                    for (int k = 0; k < 2; k++) begin
                        pend_val[k] <= cur_val[k]; pend_row[k] <= cur_row[k];
                        pend_col[k] <= cur_col[k]; pend_sum[k] <= cur_sum[k];
                    end
                end
                1: if (abort) ph <= 0;
                   else if (cnt == N / L - 1) begin
                       ph <= 2;
                       for (int k = 0; k < 2; k++) begin
                           exp_val[k] <= pend_val[k]; exp_row[k] <= pend_row[k];
                           exp_col[k] <= pend_col[k]; exp_sum[k] <= pend_sum[k];
                       end
                   end else cnt <= cnt + 1;
                default: if (abort || out_ready) ph <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("in_ready_u",  32'(bus_u.in_ready),  32'(ph == 0));
        chk("in_ready_s",  32'(bus_s.in_ready),  32'(ph == 0));
        chk("out_valid_u", 32'(bus_u.out_valid), 32'(ph == 2));
        chk("out_valid_s", 32'(bus_s.out_valid), 32'(ph == 2));
        chk("busy_u",      32'(bus_u.busy),      32'(ph != 0));
        chk("result_u",    32'(bus_u.result),     32'(exp_val[0]) & 32'hFF);
        chk("result_s",    32'(bus_s.result),     32'(exp_val[1]) & 32'hFF);
        chk("row_u",       32'(bus_u.result_row), 32'(exp_row[0]));
        chk("row_s",       32'(bus_s.result_row), 32'(exp_row[1]));
        chk("col_u",       32'(bus_u.result_col), 32'(exp_col[0]));
        chk("col_s",       32'(bus_s.result_col), 32'(exp_col[1]));
`ifdef ARGSCAN_SUM_EN
        chk("sum_u", 32'(bus_u.result_sum), 32'(exp_sum[0]) & 32'h3FFF);
        chk("sum_s", 32'(bus_s.result_sum), 32'(exp_sum[1]) & 32'h3FFF);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) arr[r][c] = v;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus_u.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (lat >= 100) chk("wait_valid_timeout", 32'(lat), 32'd32);
    endtask

    task automatic run_job(input bit m, output int lat);
        mode     = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after_take", 32'(bus_u.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        fill(8'd0);
        #12;
        chk("rst_in_ready", 32'(bus_u.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus_u.out_valid), 32'd0);
        chk("rst_result",   32'(bus_u.result),    32'd0);
        #10 rst = 1'b0;
        tick();

        // Unsigned max with one peak.
        fill(8'd0); arr[5][3] = 8'd200;
        run_job(1'b0, lat);
        chk("t1_latency", 32'(lat), 32'd32);
        chk("t1_result", 32'(bus_u.result), 32'd200);
        chk("t1_row", 32'(bus_u.result_row), 32'd5);
        chk("t1_col", 32'(bus_u.result_col), 32'd3);
        consume();

        // Min mode, then all-equal tie.
        fill(8'h80); arr[7][7] = 8'h01;
        run_job(1'b1, lat);
        chk("t2_result", 32'(bus_u.result), 32'h01);
        chk("t2_row", 32'(bus_u.result_row), 32'd7);
        chk("t2_col", 32'(bus_u.result_col), 32'd7);
        chk("t2_signed_result", 32'(bus_s.result), 32'h80);
        chk("t2_signed_col", 32'(bus_s.result_col), 32'd0);
        consume();
        fill(8'h42);
        run_job(1'b1, lat);
        chk("t2_tie_result", 32'(bus_u.result), 32'h42);
        chk("t2_tie_row", 32'(bus_u.result_row), 32'd0);
        chk("t2_tie_col", 32'(bus_u.result_col), 32'd0);
        consume();

        // Signed max over negative data.
        fill(8'hFB); arr[2][6] = 8'hFF;
        run_job(1'b0, lat);
        chk("t3_result", 32'(bus_s.result), 32'hFF);
        chk("t3_row", 32'(bus_s.result_row), 32'd2);
        chk("t3_col", 32'(bus_s.result_col), 32'd6);
        consume();

        // Mixed pattern, both modes.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) arr[r][c] = 8'(r * 37 + c * 11);
        run_job(1'b1, lat); consume();
        run_job(1'b0, lat); consume();

        // Backpressure with a second request held high.
        fill(8'd3); arr[6][1] = 8'd9;
        run_job(1'b0, lat);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_in_ready", 32'(bus_u.in_ready), 32'd0);
            chk("t4_result", 32'(bus_u.result), 32'd9);
            tick();
        end
        in_valid = 1'b0;
        consume();

        // Abort mid-scan, then a clean job.
        fill(8'd10); arr[4][4] = 8'd77;
        mode = 1'b0; in_valid = 1'b1; tick(); in_valid = 1'b0;
        repeat (9) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_busy", 32'(bus_u.busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            chk("t5_no_valid", 32'(bus_u.out_valid), 32'd0);
            tick();
        end
        run_job(1'b0, lat);
        chk("t5_result", 32'(bus_u.result), 32'd77);
        chk("t5_row", 32'(bus_u.result_row), 32'd4);
        consume();

        // Abort together with in_valid while idle: the accept wins.
        fill(8'd1); arr[0][1] = 8'd2;
        mode = 1'b0; in_valid = 1'b1; abort = 1'b1; tick();
        in_valid = 1'b0; abort = 1'b0;
        chk("t5_accept_wins", 32'(bus_u.busy), 32'd1);
        wait_valid(lat);
        consume();

        // Asynchronous reset while holding a result.
        fill(8'd0); arr[1][1] = 8'd5;
        run_job(1'b0, lat);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(bus_u.out_valid), 32'd0);
        chk("t5_rst_result", 32'(bus_u.result), 32'd0);
        chk("t5_rst_row", 32'(bus_u.result_row), 32'd0);
        #2 rst = 1'b0;
        tick();

`ifdef ARGSCAN_SUM_EN
        fill(8'd1);
        run_job(1'b0, lat);
        chk("t6_sum_ones", 32'(bus_u.result_sum), 32'd64);
        consume();
        fill(8'd255);
        run_job(1'b0, lat);
        chk("t6_sum_255", 32'(bus_u.result_sum), 32'd16320);
        consume();
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
